// File: rtl/rate_seq_pkg.sv
// Shared types and constants for the gyro rate sequencer: FSM states,
// SPI command words, read base address and calibration sample count.
package rate_seq_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        CFG0     = 3'd1,
        CFG1     = 3'd2,
        IDLE     = 3'd3,
        RD       = 3'd4,
        CAPT     = 3'd5,
        DONE_V   = 3'd6
    } state_t;

    localparam logic [15:0] CFG0_CMD    = 16'h0D02;
    localparam logic [15:0] CFG1_CMD    = 16'h1160;
    localparam logic [7:0]  RD_BASE     = 8'hA2;
    localparam logic [2:0]  LAST_BYTE   = 3'd5;
    localparam int          CAL_SAMPLES = 8;

    // Clamp a 19-bit signed difference into the 16-bit signed rate range.
    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v[18:15] == 4'b0000 || v[18:15] == 4'b1111)
            return v[15:0];
        else if (v[18])
            return 16'sh8000;
        else
            return 16'sh7FFF;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Brings the asynchronous gyro INT line into the clk domain and emits a
// single-cycle pulse on each rising edge of the synchronized level.
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/rate_seq.sv
// Gyro rate sequencer: power-up wait, SPI configuration, then a six-byte rate
// read per INT edge. Optional startup offset calibration: RATE_OFFSET_CAL_EN.
module rate_seq
    import rate_seq_pkg::*;
#(
    parameter int PWR_UP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    input  logic               done,
    input  logic [15:0]        rd_data,
    output logic               wrt,
    output logic [15:0]        cmd,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] roll_rt,
    output logic signed [15:0] yaw_rt,
    output logic               vld
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PWR_UP_W-1:0] r_pwr_cnt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic [7:0]          r_byte [0:4];
    logic                r_pend;
    logic                w_int_edge;
    logic                w_pend_set;
    logic                w_pend_clr;
    logic                r_wrt;
    logic [15:0]         r_cmd;
    logic [15:0]         w_cmd_nxt;
    logic                w_issue;
    logic                w_capt;
    logic                w_burst_end;
    logic                w_pub;
    logic                r_vld;
    logic signed [15:0]  w_raw     [3];
    logic signed [15:0]  w_pub_val [3];
    logic signed [15:0]  r_rate    [3];
    logic                w_unused_rd_hi;

    int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (INT),
        .o_pulse (w_int_edge)
    );

    // Edges before configuration completes refer to an unconfigured gyro.
    assign w_pend_set     = w_int_edge && (r_state inside {IDLE, RD, CAPT, DONE_V});
    assign w_unused_rd_hi = ^rd_data[15:8];

    assign w_raw[0] = {r_byte[1], r_byte[0]};
    assign w_raw[1] = {r_byte[3], r_byte[2]};
    assign w_raw[2] = {rd_data[7:0], r_byte[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= PWR_WAIT;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cmd_nxt   = r_cmd;
        w_issue     = 1'b0;
        w_capt      = 1'b0;
        w_burst_end = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            PWR_WAIT: begin
                if (&r_pwr_cnt) begin
                    w_state_nxt = CFG0;
                    w_issue     = 1'b1;
                    w_cmd_nxt   = CFG0_CMD;
                end
            end
            CFG0: begin
                if (done) begin
                    w_state_nxt = CFG1;
                    w_issue     = 1'b1;
                    w_cmd_nxt   = CFG1_CMD;
                end
            end
            CFG1: begin
                if (done)
                    w_state_nxt = IDLE;
            end
            IDLE: begin
                if (r_pend) begin
                    w_state_nxt = RD;
                    w_idx_nxt   = 3'd0;
                    w_pend_clr  = 1'b1;
                end
            end
            RD: begin
                w_state_nxt = CAPT;
                w_issue     = 1'b1;
                w_cmd_nxt   = {RD_BASE + {5'd0, r_idx}, 8'h00};
            end
            CAPT: begin
                if (done) begin
                    w_capt = 1'b1;
                    if (r_idx == LAST_BYTE) begin
                        w_state_nxt = DONE_V;
                        w_burst_end = 1'b1;
                    end else begin
                        w_state_nxt = RD;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end
            end
            DONE_V: begin
                if (r_pend) begin
                    w_state_nxt = RD;
                    w_idx_nxt   = 3'd0;
                    w_pend_clr  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = PWR_WAIT;
        endcase
    end

    // NOTE: the byte and rate arrays are reset explicitly; they feed outputs that must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_cnt <= '0;
            r_idx     <= 3'd0;
            r_pend    <= 1'b0;
            r_wrt     <= 1'b0;
            r_cmd     <= 16'h0000;
            r_vld     <= 1'b0;
            for (int i = 0; i < 5; i++) r_byte[i] <= 8'h00;
            for (int a = 0; a < 3; a++) r_rate[a] <= 16'sh0000;
        end else begin
            r_wrt <= w_issue;
            r_cmd <= w_cmd_nxt;
            r_idx <= w_idx_nxt;
            r_vld <= w_pub;
            if (r_state == PWR_WAIT)
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
            if (w_pend_set)
                r_pend <= 1'b1;
            else if (w_pend_clr)
                r_pend <= 1'b0;
            if (w_capt && r_idx != LAST_BYTE)
                r_byte[r_idx] <= rd_data[7:0];
            if (w_pub)
                for (int a = 0; a < 3; a++) r_rate[a] <= w_pub_val[a];
        end
    end

`ifdef RATE_OFFSET_CAL_EN
    logic [3:0]         r_cal_cnt;
    logic signed [18:0] r_acc [3];
    logic signed [18:0] w_off [3];
    logic               w_cal_done;

    assign w_cal_done = (r_cal_cnt == 4'(CAL_SAMPLES));
    assign w_pub      = w_burst_end & w_cal_done;

    // Offset is kept in its own signed net so >>> stays arithmetic.
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            w_off[a]     = r_acc[a] >>> 3;
            w_pub_val[a] = sat16($signed({{3{w_raw[a][15]}}, w_raw[a]}) - w_off[a]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cal_cnt <= 4'd0;
            for (int a = 0; a < 3; a++) r_acc[a] <= 19'sd0;
        end else if (w_burst_end && !w_cal_done) begin
            r_cal_cnt <= r_cal_cnt + 4'd1;
            for (int a = 0; a < 3; a++)
                r_acc[a] <= r_acc[a] + $signed({{3{w_raw[a][15]}}, w_raw[a]});
        end
    end
`else
    assign w_pub = w_burst_end;

    always_comb begin
        for (int a = 0; a < 3; a++) w_pub_val[a] = w_raw[a];
    end
`endif

    assign wrt     = r_wrt;
    assign cmd     = r_cmd;
    assign vld     = r_vld;
    assign ptch_rt = r_rate[0];
    assign roll_rt = r_rate[1];
    assign yaw_rt  = r_rate[2];

endmodule

// File: tb/tb_rate_seq.sv
// Randomized bench for rate_seq: an SPI slave model serves gyro bytes and a
// behavioural rate/calibration model predicts every published sample.
module tb_rate_seq;

    localparam int PW = 4;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               INT     = 1'b0;
    logic               done    = 1'b0;
    logic [15:0]        rd_data = 16'h0000;
    logic               wrt;
    logic [15:0]        cmd;
    logic signed [15:0] ptch_rt;
    logic signed [15:0] roll_rt;
    logic signed [15:0] yaw_rt;
    logic               vld;

    always #5 clk = ~clk;

    rate_seq #(.PWR_UP_W(PW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .roll_rt (roll_rt),
        .yaw_rt  (yaw_rt),
        .vld     (vld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Gyro register contents and SPI slave bookkeeping.
    logic [15:0] g_rate [3];
    logic [15:0] q_cmd [$];
    int          q_wrt_cyc [$];
    int          done_cnt      = 0;
    int          last_done_cyc = 0;
    int          lat_min       = 1;
    int          lat_max       = 4;

    function automatic logic [7:0] serve_byte(input logic [15:0] c);
        int          idx;
        logic [15:0] v;
        idx = int'(c[15:8]) - 'hA2;
        if (idx >= 0 && idx < 6) begin
            v = g_rate[idx / 2];
            return (idx % 2) ? v[15:8] : v[7:0];
        end
        return 8'($urandom);
    endfunction

    initial begin
        @(posedge clk);
        #1;
        forever begin
            if (rst_n && wrt) begin
                q_cmd.push_back(cmd);
                q_wrt_cyc.push_back(cyc);
                repeat ($urandom_range(lat_max, lat_min)) @(posedge clk);
                #1;
                rd_data       = {8'($urandom), serve_byte(cmd)};
                done          = 1'b1;
                last_done_cyc = cyc;
                done_cnt++;
                @(posedge clk);
                #1;
                done = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    end

    // Protocol monitor: pulse widths, transaction overlap, vld timing.
    int   vld_cnt = 0, vld_cyc = 0, overlap = 0, wide = 0, outstanding = 0;
    logic prev_wrt = 1'b0, prev_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_wrt    = 1'b0;
            prev_vld    = 1'b0;
        end else begin
            if (done && outstanding > 0) outstanding--;
            if (wrt) begin
                if (prev_wrt) wide++;
                else begin
                    if (outstanding != 0) overlap++;
                    outstanding++;
                end
            end
            if (vld) begin
                vld_cnt++;
                vld_cyc = cyc;
                if (prev_vld) wide++;
            end
            prev_wrt = wrt;
            prev_vld = vld;
        end
    end

    // Reference model: what the outputs should show after each completed burst.
    int          n_cal;
    int          sum [3];
    logic [15:0] exp_rate [3];

    function automatic logic [15:0] clamp16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic model_reset();
        n_cal = 0;
        for (int a = 0; a < 3; a++) begin
            sum[a]      = 0;
            exp_rate[a] = 16'h0000;
        end
    endtask

    task automatic model_burst(output bit pub);
`ifdef RATE_OFFSET_CAL_EN
        if (n_cal < 8) begin
            for (int a = 0; a < 3; a++) sum[a] += int'($signed(g_rate[a]));
            n_cal++;
            pub = 1'b0;
        end else begin
            for (int a = 0; a < 3; a++)
                exp_rate[a] = clamp16(int'($signed(g_rate[a])) - (sum[a] >>> 3));
            pub = 1'b1;
        end
`else
        for (int a = 0; a < 3; a++) exp_rate[a] = g_rate[a];
        pub = 1'b1;
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 600) begin
            @(posedge clk);
            k++;
        end
        check({tag, " done count"}, done_cnt, target);
    endtask

    task automatic check_rates(input string tag);
        check({tag, " ptch"}, $unsigned(ptch_rt), exp_rate[0]);
        check({tag, " roll"}, $unsigned(roll_rt), exp_rate[1]);
        check({tag, " yaw"},  $unsigned(yaw_rt),  exp_rate[2]);
    endtask

    task automatic release_and_config(input string tag);
        int c0;
        int k = 0;
        q_cmd.delete();
        q_wrt_cyc.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0    = cyc;
        while (q_cmd.size() < 2 && k < 200) begin
            tick(1);
            k++;
        end
        check({tag, " first wrt cycle"}, (q_wrt_cyc.size() > 0) ? q_wrt_cyc[0] - c0 : -1, 16);
        check({tag, " cmd0"}, (q_cmd.size() > 0) ? q_cmd[0] : 16'hDEAD, 16'h0D02);
        check({tag, " cmd1"}, (q_cmd.size() > 1) ? q_cmd[1] : 16'hDEAD, 16'h1160);
        tick(40);
        check({tag, " idle wrt count"}, q_cmd.size(), 2);
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        tick(3);
    endtask

    task automatic do_burst(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                            input string tag);
        bit pub;
        int v0, d0;
        g_rate[0] = p;
        g_rate[1] = r;
        g_rate[2] = y;
        model_burst(pub);
        v0 = vld_cnt;
        d0 = done_cnt;
        q_cmd.delete();
        pulse_int();
        wait_dones(d0 + 6, tag);
        tick(3);
        check({tag, " vld pulses"}, vld_cnt - v0, 32'(pub));
        if (pub) check({tag, " vld latency"}, vld_cyc - last_done_cyc, 1);
        check_rates(tag);
        check({tag, " cmd count"}, q_cmd.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s cmd%0d", tag, i), (i < q_cmd.size()) ? q_cmd[i] : 16'hDEAD,
                  {8'hA2 + 8'(i), 8'h00});
    endtask

    logic [15:0] edge_vals [6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h00FF};

    initial begin
        bit pub1, pub2;
        int v0, d0;

        model_reset();
        for (int a = 0; a < 3; a++) g_rate[a] = 16'h0000;
        tick(3);
        check("reset wrt",  wrt, 0);
        check("reset vld",  vld, 0);
        check("reset cmd",  cmd, 0);
        check_rates("reset");

        release_and_config("cfg");

`ifdef RATE_OFFSET_CAL_EN
        for (int i = 0; i < 8; i++)
            do_burst(16'h0010, 16'($urandom), 16'($urandom), $sformatf("cal%0d", i));
        do_burst(16'h0015, 16'($urandom), 16'($urandom), "cal9");
        check("cal9 ptch literal", $unsigned(ptch_rt), 16'h0005);
        do_burst(16'h8000, 16'($urandom), 16'($urandom), "sat");
        check("sat ptch literal", $unsigned(ptch_rt), 16'h8000);
`endif

        do_burst(16'h1234, 16'hABCD, 16'h0001, "fixed");
`ifndef RATE_OFFSET_CAL_EN
        check("fixed ptch literal", $unsigned(ptch_rt), 16'h1234);
        check("fixed roll literal", $unsigned(roll_rt), 16'hABCD);
        check("fixed yaw literal",  $unsigned(yaw_rt),  16'h0001);
`endif

        for (int i = 0; i < 10; i++) begin
            lat_max = $urandom_range(4, 1);
            if (i < 6)
                do_burst(edge_vals[i], edge_vals[(i + 1) % 6], 16'($urandom), $sformatf("edge%0d", i));
            else
                do_burst(16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", i));
        end

        // Two extra INT edges while a burst runs collapse into one pending read.
        lat_min = 4;
        lat_max = 4;
        for (int a = 0; a < 3; a++) g_rate[a] = 16'($urandom);
        model_burst(pub1);
        model_burst(pub2);
        v0 = vld_cnt;
        d0 = done_cnt;
        q_cmd.delete();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        for (int k = 0; k < 50 && q_cmd.size() == 0; k++) tick(1);
        repeat (2) pulse_int();
        wait_dones(d0 + 12, "dbl");
        tick(40);
        check("dbl vld pulses", vld_cnt - v0, 32'(pub1) + 32'(pub2));
        check("dbl total dones", done_cnt - d0, 12);
        check("dbl cmd count", q_cmd.size(), 12);
        check_rates("dbl");

        // Reset after the third done of a burst must abandon it.
        for (int a = 0; a < 3; a++) g_rate[a] = 16'($urandom);
        v0 = vld_cnt;
        d0 = done_cnt;
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_dones(d0 + 3, "mid");
        #1;
        rst_n = 1'b0;
        model_reset();
        tick(10);
        check("mid vld pulses", vld_cnt - v0, 0);
        check("mid wrt", wrt, 0);
        check_rates("mid");
        lat_min = 1;
        release_and_config("rst");
        do_burst(16'($urandom), 16'($urandom), 16'($urandom), "post");

        check("wrt overlap", overlap, 0);
        check("pulse width", wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
